// File: rtl/per2axi_issue_pkg.sv
// Shared types and helpers for the peripheral-to-AXI issue controller.
package per2axi_issue_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AW_PEND = 2'd1,
    AR_PEND = 2'd2,
    DRAIN   = 2'd3
  } state_e;

  // Bits needed to hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    int w;
    w = 1;
    while ((1 << w) < (max_out + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/per2axi_txn_cnt.sv
// Saturating up/down outstanding-transaction counter with a sticky underflow flag.
module per2axi_txn_cnt #(
  parameter int MAX = 8,
  parameter int W   = per2axi_issue_pkg::cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: if (cnt != W'(MAX)) cnt <= cnt + 1'b1;
        2'b01: begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/per2axi_issue_ctrl.sv
// AW/AR issue arbiter with outstanding tracking and flush handshake.
// Optional read-after-write ordering is enabled by defining PER2AXI_RAW_ORDER_EN.
module per2axi_issue_ctrl
  import per2axi_issue_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_req_i,
  output logic             wr_gnt_o,
  input  logic             rd_req_i,
  output logic             rd_gnt_o,
  output logic             aw_valid_o,
  input  logic             aw_ready_i,
  output logic             ar_valid_o,
  input  logic             ar_ready_i,
  input  logic             b_done_i,
  input  logic             r_done_i,
  input  logic             flush_req_i,
  output logic             flush_ack_o,
  output logic [CNT_W-1:0] wr_outstanding_o,
  output logic [CNT_W-1:0] rd_outstanding_o,
  output logic             busy_o,
  output logic             err_o
);

  state_e state_q, state_d;
  logic   last_wr_q, last_wr_d;
  logic   flush_ack_q, flush_ack_d;
  logic   aw_valid_q, ar_valid_q;
  logic   wr_elig, rd_elig, raw_ok;
  logic   wr_err, rd_err;

  assign wr_gnt_o = aw_valid_q & aw_ready_i;
  assign rd_gnt_o = ar_valid_q & ar_ready_i;

  per2axi_txn_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_wr_cnt (
    .clk(clk_i), .rst(rst_i), .inc(wr_gnt_o), .dec(b_done_i),
    .cnt(wr_outstanding_o), .err(wr_err)
  );

  per2axi_txn_cnt #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_rd_cnt (
    .clk(clk_i), .rst(rst_i), .inc(rd_gnt_o), .dec(r_done_i),
    .cnt(rd_outstanding_o), .err(rd_err)
  );

`ifdef PER2AXI_RAW_ORDER_EN
  assign raw_ok = (wr_outstanding_o == '0) && (state_q != AW_PEND);
`else
  assign raw_ok = 1'b1;
`endif

  assign wr_elig = wr_req_i && (wr_outstanding_o < CNT_W'(MAX_OUTSTANDING));
  assign rd_elig = rd_req_i && (rd_outstanding_o < CNT_W'(MAX_OUTSTANDING)) && raw_ok;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    flush_ack_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The ack cycle still sees the held flush level; do not re-enter DRAIN.
        if (flush_req_i && !flush_ack_q)           state_d = DRAIN;
        else if (wr_elig && (!rd_elig || !last_wr_q)) state_d = AW_PEND;
        else if (rd_elig)                          state_d = AR_PEND;
      end
      AW_PEND: if (aw_ready_i) begin
        state_d   = IDLE;
        last_wr_d = 1'b1;
      end
      AR_PEND: if (ar_ready_i) begin
        state_d   = IDLE;
        last_wr_d = 1'b0;
      end
      DRAIN: if ((wr_outstanding_o == '0) && (rd_outstanding_o == '0)) begin
        flush_ack_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_wr_q   <= 1'b0;
      flush_ack_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      ar_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_wr_q   <= last_wr_d;
      flush_ack_q <= flush_ack_d;
      aw_valid_q  <= (state_d == AW_PEND);
      ar_valid_q  <= (state_d == AR_PEND);
    end
  end

  assign aw_valid_o  = aw_valid_q;
  assign ar_valid_o  = ar_valid_q;
  assign flush_ack_o = flush_ack_q;
  assign busy_o      = (state_q != IDLE) || (wr_outstanding_o != '0) || (rd_outstanding_o != '0);
  assign err_o       = wr_err | rd_err;

endmodule

// File: tb/tb_per2axi_issue_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a cycle model.
module tb_per2axi_issue_ctrl;

  localparam int MAX   = 2;
  localparam int CNT_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             wr_req_i = 1'b0, rd_req_i = 1'b0;
  logic             aw_ready_i = 1'b0, ar_ready_i = 1'b0;
  logic             b_done_i = 1'b0, r_done_i = 1'b0, flush_req_i = 1'b0;
  logic             wr_gnt_o, rd_gnt_o, aw_valid_o, ar_valid_o, flush_ack_o, busy_o, err_o;
  logic [CNT_W-1:0] wr_outstanding_o, rd_outstanding_o;

  int n_checks = 0;
  int n_err    = 0;

  per2axi_issue_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_req_i(wr_req_i), .wr_gnt_o(wr_gnt_o),
    .rd_req_i(rd_req_i), .rd_gnt_o(rd_gnt_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .b_done_i(b_done_i), .r_done_i(r_done_i),
    .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
    .wr_outstanding_o(wr_outstanding_o), .rd_outstanding_o(rd_outstanding_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_wr_gnt(output bit got);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (wr_gnt_o) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // Reference model: integer counts, pending-direction flags and a read-preferred
  // flag for round robin. Outputs for the current cycle are derived from it at
  // each falling edge, then it is advanced using the inputs held for that cycle.
  int m_wr, m_rd;
  bit m_err, m_prefer_rd, m_aw, m_ar, m_drain, m_ack;

  always @(negedge clk_i) begin
    int nwr, nrd;
    bit gw, gr, idle, we, re, n_ack;
    if (rst_i) begin
      m_wr = 0; m_rd = 0; m_err = 0; m_prefer_rd = 0;
      m_aw = 0; m_ar = 0; m_drain = 0; m_ack = 0;
    end
    idle = !m_aw && !m_ar && !m_drain;
    gw   = m_aw && aw_ready_i;
    gr   = m_ar && ar_ready_i;
    check("aw_valid",  aw_valid_o,       m_aw);
    check("ar_valid",  ar_valid_o,       m_ar);
    check("wr_gnt",    wr_gnt_o,         gw);
    check("rd_gnt",    rd_gnt_o,         gr);
    check("flush_ack", flush_ack_o,      m_ack);
    check("wr_cnt",    wr_outstanding_o, m_wr);
    check("rd_cnt",    rd_outstanding_o, m_rd);
    check("busy",      busy_o,           (m_wr != 0) || (m_rd != 0) || !idle);
    check("err",       err_o,            m_err);
    if (!rst_i) begin
      nwr = m_wr + int'(gw) - int'(b_done_i);
      nrd = m_rd + int'(gr) - int'(r_done_i);
      if (nwr < 0) begin nwr = 0; m_err = 1; end
      if (nrd < 0) begin nrd = 0; m_err = 1; end
      if (nwr > MAX) nwr = MAX;
      if (nrd > MAX) nrd = MAX;
      we = wr_req_i && (m_wr < MAX);
      re = rd_req_i && (m_rd < MAX);
`ifdef PER2AXI_RAW_ORDER_EN
      re = re && (m_wr == 0);
`endif
      n_ack = m_drain && (m_wr == 0) && (m_rd == 0);
      if (gw) begin m_aw = 0; m_prefer_rd = 1; end
      if (gr) begin m_ar = 0; m_prefer_rd = 0; end
      if (m_drain) m_drain = !n_ack;
      else if (idle) begin
        if (flush_req_i && !m_ack) m_drain = 1;
        else if (we && re)         begin if (m_prefer_rd) m_ar = 1; else m_aw = 1; end
        else if (we)               m_aw = 1;
        else if (re)               m_ar = 1;
      end
      m_wr = nwr; m_rd = nrd; m_ack = n_ack;
    end
  end

  initial begin
    bit got, ack_seen, rd_drop;
    int n, acks, gnt_before_ack, gnt_after_ack, viol;
    bit seq_wr[$];
    int seq_at[$];
    int wr_out, rd_out;
    bit wg, rg, fa;

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    check("rst_aw_valid", aw_valid_o, 0);
    check("rst_ar_valid", ar_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wr_cnt", wr_outstanding_o, 0);

    // Single write: request at cycle 1.
    wr_req_i = 1; aw_ready_i = 1;
    cyc();
    check("single_aw_valid_c2", aw_valid_o, 1);
    check("single_wr_gnt_c2", wr_gnt_o, 1);
    cyc(); wr_req_i = 0;
    check("single_cnt_c3", wr_outstanding_o, 1);
    check("single_aw_drop_c3", aw_valid_o, 0);
    cyc(); cyc(); b_done_i = 1;
    cyc(); b_done_i = 0;
    check("single_cnt_c6", wr_outstanding_o, 0);
    check("single_busy_c6", busy_o, 0);

    // Outstanding limit of two writes.
    wr_req_i = 1; n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n += int'(wr_gnt_o);
    end
    check("limit_gnts", n, 2);
    check("limit_cnt", wr_outstanding_o, 2);
    b_done_i = 1;
    cyc(); b_done_i = 0;
    wait_wr_gnt(got);
    check("limit_third_issue", got, 1);
    cyc(); wr_req_i = 0;
    check("limit_cnt_after", wr_outstanding_o, 2);
    b_done_i = 1;
    cyc(); cyc(); b_done_i = 0;
    check("limit_drained", wr_outstanding_o, 0);

    // Issue and response in the same cycle, then underflow.
    wr_req_i = 1;
    wait_wr_gnt(got);
    cyc();
    check("simul_cnt_pre", wr_outstanding_o, 1);
    cyc(); b_done_i = 1;
    check("simul_gnt", wr_gnt_o, 1);
    cyc(); b_done_i = 0; wr_req_i = 0;
    check("simul_cnt_hold", wr_outstanding_o, 1);
    cyc(); b_done_i = 1;
    cyc();
    check("uflow_cnt_zero", wr_outstanding_o, 0);
    check("uflow_err_not_yet", err_o, 0);
    cyc(); b_done_i = 0;
    check("uflow_cnt", wr_outstanding_o, 0);
    check("uflow_err", err_o, 1);

    // Asynchronous reset while AW is waiting for ready.
    aw_ready_i = 0; wr_req_i = 1;
    cyc(); cyc();
    check("async_aw_pre", aw_valid_o, 1);
    #2 rst_i = 1;
    #1;
    check("async_aw_drop", aw_valid_o, 0);
    check("async_err_clr", err_o, 0);
    wr_req_i = 0; aw_ready_i = 1;
    cyc(); rst_i = 0;
    ar_ready_i = 1;

`ifndef PER2AXI_RAW_ORDER_EN
    // Round robin from reset: W,R,W,R two cycles apart.
    wr_req_i = 1; rd_req_i = 1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (wr_gnt_o) begin seq_wr.push_back(1'b1); seq_at.push_back(i); end
      if (rd_gnt_o) begin seq_wr.push_back(1'b0); seq_at.push_back(i); end
    end
    wr_req_i = 0; rd_req_i = 0;
    check("rr_count", seq_wr.size(), 4);
    for (int i = 0; i < seq_wr.size(); i++) begin
      check("rr_order", seq_wr[i], (i % 2) == 0);
      if (i > 0) check("rr_spacing", seq_at[i] - seq_at[i-1], 2);
    end
    b_done_i = 1; r_done_i = 1;
    cyc(); cyc(); b_done_i = 0; r_done_i = 0;
    check("rr_drained", wr_outstanding_o + rd_outstanding_o, 0);
`endif

    // Flush with two reads outstanding and a read waiting.
    rd_req_i = 1;
    repeat (5) cyc();
    rd_req_i = 0;
    check("flush_setup_rd", rd_outstanding_o, 2);
    acks = 0; gnt_before_ack = 0; gnt_after_ack = 0; ack_seen = 0; rd_drop = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      flush_req_i = (i == 0) ? 1'b1 : (flush_req_i && !ack_seen);
      rd_req_i    = (i == 0) ? 1'b1 : (rd_req_i && !rd_drop);
      r_done_i    = (i == 2) || (i == 4);
      #1;
      if (flush_ack_o) begin acks++; ack_seen = 1; end
      if (rd_gnt_o) begin
        if (acks == 0) gnt_before_ack++;
        else           gnt_after_ack++;
        rd_drop = 1;
      end
    end
    check("flush_no_issue", gnt_before_ack, 0);
    check("flush_ack_once", acks, 1);
    check("flush_read_after", gnt_after_ack, 1);
    r_done_i = 1;
    cyc(); r_done_i = 0;

`ifdef PER2AXI_RAW_ORDER_EN
    // Read held off while a write is outstanding.
    wr_req_i = 1;
    wait_wr_gnt(got);
    cyc(); wr_req_i = 0; rd_req_i = 1; viol = 0;
    repeat (6) begin cyc(); viol += int'(ar_valid_o); end
    check("raw_hold", viol, 0);
    b_done_i = 1;
    cyc(); b_done_i = 0;
    check("raw_b1", ar_valid_o, 0);
    cyc();
    check("raw_b2", ar_valid_o, 1);
    cyc(); rd_req_i = 0; r_done_i = 1;
    cyc(); r_done_i = 0;
`endif

    // Randomized traffic from a clean reset.
    rst_i = 1;
    {wr_req_i, rd_req_i, b_done_i, r_done_i, flush_req_i} = '0;
    cyc(); rst_i = 0;
    wr_out = 0; rd_out = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_i);
      wg = wr_gnt_o; rg = rd_gnt_o; fa = flush_ack_o;
      @(posedge clk_i);
      #1;
      wr_out += int'(wg);
      rd_out += int'(rg);
      wr_req_i    = (wr_req_i && !wg) ? 1'b1 : ($urandom_range(1, 0) == 1);
      rd_req_i    = (rd_req_i && !rg) ? 1'b1 : ($urandom_range(1, 0) == 1);
      flush_req_i = (flush_req_i && !fa) ? 1'b1 : ($urandom_range(15, 0) == 0);
      aw_ready_i  = ($urandom_range(3, 0) != 0);
      ar_ready_i  = ($urandom_range(3, 0) != 0);
      b_done_i    = (wr_out > 0) && ($urandom_range(2, 0) == 0);
      r_done_i    = (rd_out > 0) && ($urandom_range(2, 0) == 0);
      wr_out     -= int'(b_done_i);
      rd_out     -= int'(r_done_i);
    end

    @(negedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/per2axi_issue_ctrl.md
# per2axi_issue_ctrl

Issue controller for the peripheral-to-AXI bridge. It arbitrates between a pending write request and a pending read request from the peripheral side, drives the AXI AW/AR valid handshakes, and tracks outstanding writes and reads against a configurable limit. It also runs a flush (drain) handshake and produces the bridge busy indication. It sits between the peripheral request decoder and the AXI address-channel drivers.

## Interface
- MAX_OUTSTANDING, 8: maximum in-flight transactions per direction; range 1..15.
- CNT_W, $clog2(MAX_OUTSTANDING+1): counter width; derived, not to be overridden.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset. One clock; reset is asynchronous and active-high.
- wr_req_i  input  1  write request pending; held high until wr_gnt_o.
- wr_gnt_o  output  1  write issued; one-cycle pulse, equal to aw_valid_o & aw_ready_i.
- rd_req_i  input  1  read request pending; held high until rd_gnt_o.
- rd_gnt_o  output  1  read issued; one-cycle pulse, equal to ar_valid_o & ar_ready_i.
- aw_valid_o  output  1  AW valid, registered.
- aw_ready_i  input  1  AW ready.
- ar_valid_o  output  1  AR valid, registered.
- ar_ready_i  input  1  AR ready.
- b_done_i  input  1  B handshake completed this cycle.
- r_done_i  input  1  last R beat handshake completed this cycle.
- flush_req_i  input  1  drain request; level, held until flush_ack_o.
- flush_ack_o  output  1  drain complete; one-cycle pulse.
- wr_outstanding_o  output  CNT_W  outstanding write count.
- rd_outstanding_o  output  CNT_W  outstanding read count.
- busy_o  output  1  high when either count is nonzero or state is not IDLE.
- err_o  output  1  sticky underflow error; cleared only by reset.

## Operation
- FSM states:
  - IDLE: arbitrates between requests.
  - AW_PEND: holds aw_valid_o high.
  - AR_PEND: holds ar_valid_o high.
  - DRAIN: waits for all outstanding transactions to complete.
- Write eligibility: wr_req_i & wr_cnt < MAX_OUTSTANDING. Read eligibility: rd_req_i & rd_cnt < MAX_OUTSTANDING.
- IDLE transitions:
  - flush_req_i high: go to DRAIN. Flush has priority over new requests.
  - Otherwise, one eligible requester: go to its PEND state.
  - Otherwise, both eligible: round-robin. The direction not issued last wins. After reset, write wins.
- AW_PEND: on aw_ready_i, pulse wr_gnt_o, update the last-issued flag, and return to IDLE. AR_PEND behaves the same way with ar_ready_i and rd_gnt_o.
- Once a valid is asserted it is never deasserted before ready, even if flush_req_i rises or rst is absent.
- DRAIN: no new issues. When wr_cnt == 0 and rd_cnt == 0, pulse flush_ack_o and return to IDLE.
- Counters:
  - Increment on an address handshake; decrement on b_done_i or r_done_i respectively.
  - Increment and decrement in the same cycle: count unchanged.
  - Decrement at 0: count stays 0 and err_o is set.
  - The count cannot exceed MAX_OUTSTANDING, because issue is gated by eligibility.

## Timing
- Reset values: state IDLE; all valids, grants, flush_ack_o, busy_o and err_o are 0; counts are 0; round-robin priority is write-first.
- Issue sequence for a request first seen in IDLE at cycle t:
  - valid rises at t+1.
  - With ready high at t+1, the grant pulses at t+1 and the count shows +1 at t+2.
  - The next issue's valid rises no earlier than t+3.
- Peak issue rate: one issue per 2 cycles.
- Responses: b_done_i/r_done_i at cycle t are reflected in the count at t+1.
- Flush: flush_ack_o pulses in the first DRAIN cycle in which both counts are 0.
  - With nothing outstanding, flush_req_i at t gives the ack at t+2: DRAIN is entered at t+1 and the ack is visible in the t+1 cycle's registered output.
  - flush_ack_o is registered.
- Asynchronous reset mid-transaction drops valids immediately. The AXI side must be reset together with this block.

## Configuration
- PER2AXI_RAW_ORDER_EN defined: a read is not eligible while wr_cnt != 0 or state is AW_PEND. This enforces read-after-write ordering.
- Undefined: reads and writes are independent, subject only to the limits and round-robin.

## Structure
- Package per2axi_issue_pkg holds:
  - the FSM state enum (IDLE, AW_PEND, AR_PEND, DRAIN);
  - the CNT_W helper function.
- Sub-module per2axi_txn_cnt: a saturating up/down counter with an underflow flag. It is instantiated twice, once for writes and once for reads.

## Test plan
- Single write, aw_ready_i high: wr_req_i at cycle 1 → aw_valid_o at 2, wr_gnt_o at 2, wr_outstanding_o=1 at 3; b_done_i at 5 → count 0 and busy_o 0 at 6.
- Both requests held continuously, readies high: grants alternate W,R,W,R; each grant is 2 cycles apart.
- Limit: MAX_OUTSTANDING=2, 3 writes with no B → the third write is never granted; one b_done_i → the third write issues.
- Simultaneous aw handshake and b_done_i with count 1 → count stays 1. b_done_i with count 0 → count 0 and err_o latched 1.
- Flush with 2 reads outstanding: flush_req_i high and rd_req_i pending → no rd_gnt_o; after two r_done_i, flush_ack_o pulses exactly once.
- With PER2AXI_RAW_ORDER_EN, 1 write outstanding and rd_req_i high → ar_valid_o stays 0 until b_done_i; ar_valid_o rises 2 cycles after b_done_i.
